sevenseg_scan8: RTL and testbench

Time-multiplexed scan controller for the 8-digit seven-segment display. Accepts eight 7-bit digit codes in the `sevenseg_ext_n` data format, drives them one at a time through an internal `sevenseg_ext_n` decoder, and cycles the active-low anodes, replacing the fixed single-anode drive with a full 8-digit display. Inserts a blanking gap between digits to suppress ghosting. Double-buffers the digit data so that every displayed frame is consistent.

---
 rtl/sevenseg_pkg.sv | 36 +++
 rtl/sevenseg_ext_n.sv | 20 ++
 rtl/sevenseg_scan8.sv | 130 +++++++++++++
 tb/tb_sevenseg_scan8.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and glyph table for the seven-segment scan controller.
// Digit code format: [3:0] hex value, [4] dp lit, [5] minus sign, [6] blank (overrides all).
package sevenseg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 7;
  localparam int unsigned IDX_W      = 3;

  typedef logic [6:0] digit_t;
  typedef enum logic {BLANK, ON} scan_state_t;

  // Active-high segment pattern for a hex nibble, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sevenseg_ext_n.sv
// Combinational decoder from a digit code to active-low segments and decimal point.
module sevenseg_ext_n
  import sevenseg_pkg::*;
(
  input  digit_t     code,
  output logic [6:0] segs_n_c,
  output logic       dp_n_c
);

  always_comb begin
    segs_n_c = ~hex_glyph(code[3:0]);
    if (code[6]) begin
      segs_n_c = 7'h7F;
    end else if (code[5]) begin
      segs_n_c = 7'h3F;
    end
    dp_n_c = code[6] | ~code[4];
  end

endmodule

// File: rtl/sevenseg_scan8.sv
// Eight-digit multiplexed scan controller with blanking gaps and frame-aligned double buffering.
module sevenseg_scan8
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIG_CYCLES   = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   digits,
  input  logic                            load,
  input  logic [NUM_DIGITS-1:0]           en_mask,
  output logic [6:0]                      segs_n,
  output logic                            dp_n,
  output logic [NUM_DIGITS-1:0]           an_n,
  output logic                            frame_tick
);

  localparam int unsigned BUF_W   = NUM_DIGITS * DIGIT_W;
  localparam int unsigned MAX_CYC = (DIG_CYCLES > BLANK_CYCLES) ? DIG_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [BUF_W-1:0] shadow, active, active_nxt;
  logic             pending;
  logic             frame_end_c;
  digit_t           cur_code;
  logic [6:0]       dec_segs_n;
  logic             dec_dp_n;

  // Phase sequencing; the registered outputs trail this state by one clock.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    idx_nxt     = idx;
    frame_end_c = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          state_nxt = ON;
          cnt_nxt   = '0;
        end
      end
      ON: begin
        if (cnt == CNT_W'(DIG_CYCLES - 1)) begin
          state_nxt   = BLANK;
          cnt_nxt     = '0;
          idx_nxt     = idx + IDX_W'(1);
          frame_end_c = (idx == IDX_W'(NUM_DIGITS - 1));
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // frame_tick marks the last displayed cycle; the following edge is the frame boundary.
  always_comb begin
    active_nxt = active;
    if (frame_tick) begin
      if (load) begin
        active_nxt = digits;
      end else if (pending) begin
        active_nxt = shadow;
      end
    end
  end

  assign cur_code = active_nxt[32'(idx) * DIGIT_W +: DIGIT_W];

  sevenseg_ext_n u_dec (
    .code     (cur_code),
    .segs_n_c (dec_segs_n),
    .dp_n_c   (dec_dp_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      active <= active_nxt;
      if (load) begin
        shadow  <= digits;
        pending <= ~frame_tick;
      end else if (frame_tick) begin
        pending <= 1'b0;
      end
    end
  end

  // Segments refresh only on the first blanking cycle, so they settle before the anode drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segs_n     <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end_c;
      if (state == BLANK) begin
        an_n <= '1;
        if (cnt == '0) begin
          segs_n <= dec_segs_n;
          dp_n   <= dec_dp_n;
        end
      end else if (cnt == '0) begin
        an_n <= en_mask[idx] ? ~(NUM_DIGITS'(1) << idx) : '1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan8.sv
// Randomized self-checking bench for sevenseg_scan8 against a frame-position reference model.
module tb_sevenseg_scan8;

  localparam int DIG   = 4;
  localparam int BLK   = 2;
  localparam int SLOT  = DIG + BLK;
  localparam int FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [55:0] digits = '0;
  logic        load = 1'b0;
  logic [7:0]  en_mask = 8'hFF;
  logic [6:0]  segs_n;
  logic        dp_n;
  logic [7:0]  an_n;
  logic        frame_tick;

  always #5 clk = ~clk;

  sevenseg_scan8 #(.DIG_CYCLES(DIG), .BLANK_CYCLES(BLK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .load       (load),
    .en_mask    (en_mask),
    .segs_n     (segs_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: clock index since reset release plus the data shown in the current frame.
  int          k;
  logic [55:0] m_frame, m_shadow;
  logic        m_pending, m_slot_en;
  logic [7:0]  exp_an;
  logic [6:0]  exp_segs;
  logic        exp_dp, exp_tick;

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Returns {dp_n, segs_n} for a digit code.
  function automatic logic [7:0] glyph_n(input logic [6:0] code);
    logic [6:0] s;
    if (code[6]) return 8'hFF;
    s = code[5] ? 7'h40 : hex_tbl[code[3:0]];
    return {~code[4], ~s};
  endfunction

  function automatic logic [55:0] rand_digits();
    return 56'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    k = -1;
    m_frame = '0;
    m_shadow = '0;
    m_pending = 1'b0;
    m_slot_en = 1'b0;
  endtask

  // Advance one clock and compute what the outputs must show in the new cycle.
  task automatic tick_cycle();
    logic        ld;
    logic [55:0] dg;
    logic [7:0]  msk;
    int p, d, q;
    ld = load; dg = digits; msk = en_mask;
    @(posedge clk); #1;
    k++;
    p = k % FRAME; d = p / SLOT; q = p % SLOT;
    if (k > 0 && ld) begin
      if (p == 0) begin m_frame = dg; m_pending = 1'b0; end
      else begin m_shadow = dg; m_pending = 1'b1; end
    end else if (k > 0 && p == 0 && m_pending) begin
      m_frame = m_shadow; m_pending = 1'b0;
    end
    if (q == BLK) m_slot_en = msk[d];
    exp_an = (q >= BLK && m_slot_en) ? ~(8'b1 << d) : 8'hFF;
    {exp_dp, exp_segs} = glyph_n(m_frame[7*d +: 7]);
    exp_tick = (p == FRAME - 1);
  endtask

  task automatic test_reset();
    load = 1'b0; digits = '0; en_mask = 8'hFF; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (an_n !== 8'hFF || segs_n !== 7'h7F || dp_n !== 1'b1 || frame_tick !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_hold: an=%h segs=%h dp=%b tick=%b, want FF 7F 1 0", an_n, segs_n, dp_n, frame_tick);
    end
    @(negedge clk); rst_n = 1'b1; model_reset();
    for (int i = 0; i < FRAME + 4; i++) begin
      tick_cycle();
      compared++;
      if ({an_n, segs_n, dp_n, frame_tick} !== {exp_an, exp_segs, exp_dp, exp_tick}) begin
        mismatched++;
        $display("FAIL reset_scan k=%0d: got an=%h segs=%h dp=%b tick=%b, want an=%h segs=%h dp=%b tick=%b",
                 k, an_n, segs_n, dp_n, frame_tick, exp_an, exp_segs, exp_dp, exp_tick);
      end
      if (k == 2 || k == 5 || k == 8 || k == 47) begin
        compared++;
        if ((k == 2 && an_n !== 8'hFE) || (k == 5 && an_n !== 8'hFE) ||
            (k == 8 && an_n !== 8'hFD) || (k == 47 && frame_tick !== 1'b1)) begin
          mismatched++;
          $display("FAIL reset_timing k=%0d: an=%h tick=%b", k, an_n, frame_tick);
        end
      end
    end
  endtask

  task automatic test_load_mid();
    int lf = -10;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      tick_cycle();
      compared++;
      if ({an_n, segs_n, dp_n, frame_tick} !== {exp_an, exp_segs, exp_dp, exp_tick}) begin
        mismatched++;
        $display("FAIL load_mid k=%0d: got an=%h segs=%h dp=%b tick=%b, want an=%h segs=%h dp=%b tick=%b",
                 k, an_n, segs_n, dp_n, frame_tick, exp_an, exp_segs, exp_dp, exp_tick);
      end
      if (k / FRAME == lf + 1 && k % FRAME < SLOT) begin
        compared++;
        if (segs_n !== 7'h12) begin
          mismatched++;
          $display("FAIL load_mid_digit5 k=%0d: segs=%h want 12", k, segs_n);
        end
      end
      load = 1'b0;
      if (lf < 0 && k % FRAME == 20) begin
        digits = rand_digits();
        digits[6:0] = 7'h05;
        load = 1'b1;
        lf = k / FRAME;
      end
    end
    load = 1'b0;
  endtask

  task automatic test_load_boundary();
    logic [55:0] nd = '0;
    bit armed = 1'b0;
    for (int i = 0; i < FRAME + 12; i++) begin
      tick_cycle();
      compared++;
      if ({an_n, segs_n, dp_n, frame_tick} !== {exp_an, exp_segs, exp_dp, exp_tick}) begin
        mismatched++;
        $display("FAIL load_boundary k=%0d: got an=%h segs=%h dp=%b tick=%b, want an=%h segs=%h dp=%b tick=%b",
                 k, an_n, segs_n, dp_n, frame_tick, exp_an, exp_segs, exp_dp, exp_tick);
      end
      if (armed) begin
        compared++;
        if ({dp_n, segs_n} !== glyph_n(nd[6:0])) begin
          mismatched++;
          $display("FAIL load_boundary_immediate k=%0d: dp/segs=%h want %h", k, {dp_n, segs_n}, glyph_n(nd[6:0]));
        end
        armed = 1'b0;
      end
      load = 1'b0;
      if (frame_tick === 1'b1 && nd == '0) begin
        nd = rand_digits();
        nd[6:0] = 7'h0A;
        digits = nd;
        load = 1'b1;
        armed = 1'b1;
      end
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [55:0] second = '0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick_cycle();
      compared++;
      if ({an_n, segs_n, dp_n, frame_tick} !== {exp_an, exp_segs, exp_dp, exp_tick}) begin
        mismatched++;
        $display("FAIL back_to_back k=%0d: got an=%h segs=%h dp=%b tick=%b, want an=%h segs=%h dp=%b tick=%b",
                 k, an_n, segs_n, dp_n, frame_tick, exp_an, exp_segs, exp_dp, exp_tick);
      end
      load = 1'b0;
      if (i < FRAME && k % FRAME == 10) begin
        digits = rand_digits(); load = 1'b1;
      end else if (i < FRAME && k % FRAME == 11) begin
        second = rand_digits(); second[6:0] = 7'h03; digits = second; load = 1'b1;
      end
    end
    load = 1'b0;
  endtask

  task automatic test_mask();
    int sf;
    en_mask = 8'b1111_0101;
    sf = k / FRAME;
    for (int i = 0; i < 2 * FRAME + 6; i++) begin
      tick_cycle();
      compared++;
      if ({an_n, segs_n, dp_n, frame_tick} !== {exp_an, exp_segs, exp_dp, exp_tick}) begin
        mismatched++;
        $display("FAIL mask k=%0d: got an=%h segs=%h dp=%b tick=%b, want an=%h segs=%h dp=%b tick=%b",
                 k, an_n, segs_n, dp_n, frame_tick, exp_an, exp_segs, exp_dp, exp_tick);
      end
      if (k / FRAME > sf && ((k % FRAME) / SLOT == 1 || (k % FRAME) / SLOT == 3)) begin
        compared++;
        if (an_n !== 8'hFF) begin
          mismatched++;
          $display("FAIL mask_off k=%0d: an=%h want FF", k, an_n);
        end
      end
    end
    en_mask = 8'hFF;
  endtask

  task automatic test_mid_reset();
    bit done = 1'b0;
    for (int i = 0; i < 2 * FRAME && !done; i++) begin
      tick_cycle();
      load = 1'b0;
      if (i == 1) begin digits = rand_digits() | 56'h1; load = 1'b1; end
      if (k % FRAME == 5 * SLOT + BLK + 1) done = 1'b1;
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL mid_reset_reach: digit 5 ON phase not reached");
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (an_n !== 8'hFF || segs_n !== 7'h7F || frame_tick !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_async: an=%h segs=%h tick=%b, want FF 7F 0", an_n, segs_n, frame_tick);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; model_reset();
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      tick_cycle();
      compared++;
      if ({an_n, segs_n, dp_n, frame_tick} !== {exp_an, exp_segs, exp_dp, exp_tick}) begin
        mismatched++;
        $display("FAIL mid_reset_restart k=%0d: got an=%h segs=%h dp=%b tick=%b, want an=%h segs=%h dp=%b tick=%b",
                 k, an_n, segs_n, dp_n, frame_tick, exp_an, exp_segs, exp_dp, exp_tick);
      end
    end
  endtask

  task automatic test_ghosting();
    logic [6:0] prev_segs;
    digits = rand_digits(); load = 1'b1;
    en_mask = 8'($urandom()) | 8'h81;
    prev_segs = segs_n;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      tick_cycle();
      load = 1'b0;
      if (i == FRAME / 2) en_mask = 8'($urandom());
      compared++;
      if ({an_n, segs_n, dp_n, frame_tick} !== {exp_an, exp_segs, exp_dp, exp_tick}) begin
        mismatched++;
        $display("FAIL ghost_model k=%0d: got an=%h segs=%h dp=%b tick=%b, want an=%h segs=%h dp=%b tick=%b",
                 k, an_n, segs_n, dp_n, frame_tick, exp_an, exp_segs, exp_dp, exp_tick);
      end
      compared++;
      if ($countones(~an_n) > 1 || (segs_n !== prev_segs && an_n !== 8'hFF)) begin
        mismatched++;
        $display("FAIL ghost_rule k=%0d: an=%h segs=%h prev_segs=%h", k, an_n, segs_n, prev_segs);
      end
      prev_segs = segs_n;
    end
    en_mask = 8'hFF;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_mid();
    test_load_boundary();
    test_back_to_back();
    test_mask();
    test_mid_reset();
    test_ghosting();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
